// File: rtl/dt_req_queue.sv
// dt_req_queue: EX->DT pipeline register plus a small FIFO of data-SRAM
// requests. The FIFO presents its head on a req/addr_ok handshake, so a slow
// SRAM port back-pressures through stallreq_q instead of freezing the bus.
module dt_req_queue #(
  parameter int BUS_WD      = 263,
  parameter int SRAM_WD     = 70,
  parameter int STALL_WD    = 6,
  parameter int STALL_IDX   = 4,
  parameter int DEPTH       = 2,
  parameter int CACHEOP_LSB = 259
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [STALL_WD-1:0] stall,
  input  logic [BUS_WD-1:0]   ex_to_dt_bus,
  input  logic [SRAM_WD-1:0]  ex_dt_sram_bus,
  output logic [BUS_WD-1:0]   dt_to_dc_bus,
  output logic                data_sram_req,
  input  logic                data_sram_addr_ok,
  output logic                data_sram_wen,
  output logic [3:0]          data_sram_sel,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  output logic                d_index_wb_invalid,
  output logic                d_index_store_tag,
  output logic                d_hit_invalid,
  output logic                d_hit_wb_invalid,
  output logic                stallreq_q,
  output logic                q_overflow
);

  // Stored entry drops the en bit: {wen, sel[3:0], addr[31:0], wdata[31:0]}.
  localparam int ENT_WD = SRAM_WD - 1;
  localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_WD = $clog2(DEPTH + 1);

  logic [BUS_WD-1:0] bus_q, bus_d;
  logic [ENT_WD-1:0] mem_q [DEPTH];
  logic [PTR_WD-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_WD-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              wr_en;

  logic stall_self, stall_next, push, pop, full, push_ok;
  logic [ENT_WD-1:0] head;
  logic stall_unused;

  function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
    return (p == PTR_WD'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign stall_self   = stall[STALL_IDX];
  assign stall_next   = stall[STALL_IDX+1];
  assign stall_unused = ^stall;  // only two bits of the stall vector matter here

  assign data_sram_req = (cnt_q != '0);
  assign full          = (cnt_q == CNT_WD'(DEPTH));
  assign pop           = data_sram_req & data_sram_addr_ok;
  assign push          = !stall_self & !flush & ex_dt_sram_bus[SRAM_WD-1];
  // A push into a full queue is still fine when the head leaves the same cycle.
  assign push_ok       = push & (pop | !full);

  // Head is read straight from storage so it stays stable until popped.
  assign head            = mem_q[rd_q];
  assign data_sram_wen   = head[ENT_WD-1];
  assign data_sram_sel   = head[ENT_WD-2 -: 4];
  assign data_sram_addr  = head[63:32];
  assign data_sram_wdata = head[31:0];

  assign stallreq_q = full;
  assign q_overflow = ovf_q;

  assign dt_to_dc_bus       = bus_q;
  assign d_index_wb_invalid = bus_q[CACHEOP_LSB+3];
  assign d_index_store_tag  = bus_q[CACHEOP_LSB+2];
  assign d_hit_invalid      = bus_q[CACHEOP_LSB+1];
  assign d_hit_wb_invalid   = bus_q[CACHEOP_LSB];

  // Bus register next state: flush, then bubble, then load, else hold.
  always_comb begin
    // NOTE: default first so every path assigns bus_d and no latch is inferred.
    bus_d = bus_q;
    if (flush)                          bus_d = '0;
    else if (stall_self && !stall_next) bus_d = '0;
    else if (!stall_self)               bus_d = ex_to_dt_bus;
  end

  // Queue pointer/count/overflow next state, including flush trimming.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    wr_en = 1'b0;
    if (flush) begin
      if (data_sram_req && !data_sram_addr_ok) begin
        // Issued head must complete; everything behind it is discarded.
        cnt_d = CNT_WD'(1);
        wr_d  = ptr_inc(rd_q);
      end else begin
        cnt_d = '0;
        rd_d  = pop ? ptr_inc(rd_q) : rd_q;
        wr_d  = rd_d;
      end
    end else begin
      if (pop) rd_d = ptr_inc(rd_q);
      if (push_ok) begin
        wr_en = 1'b1;
        wr_d  = ptr_inc(wr_q);
      end else if (push) begin
        ovf_d = 1'b1;
      end
      cnt_d = cnt_q + CNT_WD'(push_ok) - CNT_WD'(pop);
    end
  end

  // State registers, cleared asynchronously so req drops at once on reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
    if (rst) begin
      bus_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      bus_q <= bus_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry storage; written at the tail on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: storage is reset (it is tiny) so head fields read 0 after reset.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_q] <= ex_dt_sram_bus[ENT_WD-1:0];
    end
  end

endmodule
